// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between requesters A and B with locked bursts
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   a_req/a_we/a_last/a_addr/a_wdata  requester A command, held until a_gnt
//   a_gnt                         A's transfer executes this cycle (combinational)
//   a_rvalid, a_rdata             A's read result, one cycle after a granted read
//   b_*                           same set for requester B
//   ram_we/ram_addr/ram_wdata     RAM command bus, driven by the granted requester
//   ram_rdata                     registered RAM read data
//
// Build option: define RAM_ARB_RR_EN for round-robin between bursts;
// without it A has fixed priority whenever both contend in IDLE.
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_last,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_last,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    state_t state, state_nxt;
    // ptr selects the contention winner in IDLE: 0 = A, 1 = B
    logic ptr, ptr_nxt;
    logic sel_a, sel_b;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
        end
    end
    always_comb begin
        state_nxt = a_gnt ? (a_last ? IDLE : OWN_A) :
                    b_gnt ? (b_last ? IDLE : OWN_B) : state;
`ifdef RAM_ARB_RR_EN
        ptr_nxt = (a_gnt & a_last) ? 1'b1 : (b_gnt & b_last) ? 1'b0 : ptr;
`else
        ptr_nxt = 1'b0;
`endif
    end
    // An owner keeps the RAM through request gaps; the other side waits.
    always_comb begin
        sel_a     = (state == OWN_A) ? a_req : (state == OWN_B) ? 1'b0 : a_req & (~b_req | ~ptr);
        sel_b     = (state == OWN_B) ? b_req : (state == OWN_A) ? 1'b0 : b_req & (~a_req | ptr);
        a_gnt     = sel_a & ~rst;
        b_gnt     = sel_b & ~rst;
        ram_we    = a_gnt ? a_we : (b_gnt & b_we);
        ram_addr  = a_gnt ? a_addr : b_gnt ? b_addr : '0;
        ram_wdata = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    end
    assign a_rdata = ram_rdata;
    assign b_rdata = ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table plus randomized traffic against a reference model
module tb_ram_arbiter;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, a_last, b_req, b_we, b_last;
    logic [9:0] a_addr, b_addr, ram_addr;
    logic [7:0] a_wdata, b_wdata, ram_wdata, a_rdata, b_rdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
    logic [7:0] ram_rdata = 8'h00;
    logic [7:0] ram_mem [1024] = '{default: 8'h00};
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        else ram_rdata <= ram_mem[ram_addr];
    end

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_last(a_last), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_last(b_last), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    typedef struct {
        logic       r;
        logic       ar, aw, al;
        logic [9:0] aa;
        logic [7:0] ad;
        logic       br, bw, bl;
        logic [9:0] ba;
        logic [7:0] bd;
        logic       eag, ebg, earv, ebrv, chk_rd;
        logic [7:0] erd;
    } vec_t;

    typedef struct {
        logic       req, we, last;
        logic [9:0] addr;
        logic [7:0] data;
    } xfer_t;

    function automatic xfer_t rnd_xfer();
        xfer_t t;
        t.req  = 1'b1;
        t.we   = 1'($urandom_range(0, 1));
        t.last = ($urandom_range(0, 2) != 0);
        t.addr = 10'h200 + 10'($urandom_range(0, 31));
        t.data = 8'($urandom);
        return t;
    endfunction

    vec_t  v [24];
    xfer_t ta, tb_x, g;
    logic [7:0] ref_mem [1024] = '{default: 8'h00};
    int owner, turn, who;
    logic exp_arv, exp_brv;
    logic [7:0] exp_rd;

    initial begin
        v[0]  = '{0, 1,1,1,10'h005,8'h3C, 0,0,0,10'h000,8'h00, 1,0,0,0,0,8'h00};
        v[1]  = '{0, 1,0,1,10'h005,8'h00, 0,0,0,10'h000,8'h00, 1,0,0,0,0,8'h00};
        v[2]  = '{0, 0,0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,1,0,1,8'h3C};
        v[3]  = '{1, 1,0,1,10'h005,8'h00, 1,0,1,10'h010,8'h00, 0,0,0,0,0,8'h00};
        v[4]  = '{0, 1,0,1,10'h005,8'h00, 1,0,1,10'h010,8'h00, 1,0,0,0,0,8'h00};
        v[5]  = '{0, 1,0,1,10'h005,8'h00, 1,0,1,10'h010,8'h00, !RR,RR,1,0,1,8'h3C};
        v[6]  = '{0, 1,0,1,10'h005,8'h00, 1,0,1,10'h010,8'h00, 1,0,!RR,RR,0,8'h00};
        v[7]  = '{0, 1,0,1,10'h005,8'h00, 1,0,1,10'h010,8'h00, !RR,RR,1,0,1,8'h3C};
        v[8]  = '{0, 0,0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,!RR,RR,0,8'h00};
        v[9]  = '{0, 1,1,0,10'h010,8'h11, 1,0,1,10'h011,8'h00, 1,0,0,0,0,8'h00};
        v[10] = '{0, 1,1,0,10'h011,8'h22, 1,0,1,10'h011,8'h00, 1,0,0,0,0,8'h00};
        v[11] = '{0, 0,0,0,10'h000,8'h00, 1,0,1,10'h011,8'h00, 0,0,0,0,0,8'h00};
        v[12] = '{0, 0,0,0,10'h000,8'h00, 1,0,1,10'h011,8'h00, 0,0,0,0,0,8'h00};
        v[13] = '{0, 1,1,0,10'h012,8'h33, 1,0,1,10'h011,8'h00, 1,0,0,0,0,8'h00};
        v[14] = '{0, 1,1,1,10'h013,8'h44, 1,0,1,10'h011,8'h00, 1,0,0,0,0,8'h00};
        v[15] = '{0, 0,0,0,10'h000,8'h00, 1,0,1,10'h011,8'h00, 0,1,0,0,0,8'h00};
        v[16] = '{0, 0,0,0,10'h000,8'h00, 1,1,1,10'h3FF,8'hA5, 0,1,0,1,1,8'h22};
        v[17] = '{0, 1,0,1,10'h3FF,8'h00, 0,0,0,10'h000,8'h00, 1,0,0,0,0,8'h00};
        v[18] = '{0, 0,0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,1,0,1,8'hA5};
        v[19] = '{0, 0,0,0,10'h000,8'h00, 1,0,0,10'h020,8'h00, 0,1,0,0,0,8'h00};
        v[20] = '{0, 1,0,1,10'h005,8'h00, 1,0,0,10'h021,8'h00, 0,1,0,1,0,8'h00};
        v[21] = '{1, 1,0,1,10'h005,8'h00, 1,0,0,10'h021,8'h00, 0,0,0,0,0,8'h00};
        v[22] = '{0, 1,0,1,10'h005,8'h00, 0,0,0,10'h000,8'h00, 1,0,0,0,0,8'h00};
        v[23] = '{0, 0,0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,1,0,1,8'h3C};

        rst = 1'b1;
        {a_req, a_we, a_last, b_req, b_we, b_last} = '0;
        {a_addr, b_addr, a_wdata, b_wdata} = '0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset a_gnt", 32'(a_gnt), 0);
        chk("reset b_gnt", 32'(b_gnt), 0);
        chk("reset a_rvalid", 32'(a_rvalid), 0);
        chk("reset b_rvalid", 32'(b_rvalid), 0);
        chk("reset ram_addr", 32'(ram_addr), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 24; i++) begin
            rst = v[i].r;
            a_req = v[i].ar; a_we = v[i].aw; a_last = v[i].al; a_addr = v[i].aa; a_wdata = v[i].ad;
            b_req = v[i].br; b_we = v[i].bw; b_last = v[i].bl; b_addr = v[i].ba; b_wdata = v[i].bd;
            #2;
            chk($sformatf("row%0d a_gnt", i), 32'(a_gnt), 32'(v[i].eag));
            chk($sformatf("row%0d b_gnt", i), 32'(b_gnt), 32'(v[i].ebg));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we),
                32'(v[i].eag ? v[i].aw : v[i].ebg ? v[i].bw : 1'b0));
            chk($sformatf("row%0d ram_addr", i), 32'(ram_addr),
                32'(v[i].eag ? v[i].aa : v[i].ebg ? v[i].ba : 10'h0));
            chk($sformatf("row%0d ram_wdata", i), 32'(ram_wdata),
                32'(v[i].eag ? v[i].ad : v[i].ebg ? v[i].bd : 8'h0));
            chk($sformatf("row%0d a_rvalid", i), 32'(a_rvalid), 32'(v[i].earv));
            chk($sformatf("row%0d b_rvalid", i), 32'(b_rvalid), 32'(v[i].ebrv));
            if (v[i].chk_rd) chk($sformatf("row%0d rdata", i), 32'(v[i].earv ? a_rdata : b_rdata), 32'(v[i].erd));
            @(posedge clk);
            #1;
        end

        // Randomized traffic from a fresh reset, checked against the lock/turn model.
        rst = 1'b1;
        {a_req, b_req} = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        owner = 0; turn = 0;
        exp_arv = 1'b0; exp_brv = 1'b0; exp_rd = 8'h00;
        ta = '{default: '0};
        tb_x = '{default: '0};
        for (int c = 0; c < 600; c++) begin
            if (!ta.req && $urandom_range(0, 2) != 0) ta = rnd_xfer();
            if (!tb_x.req && $urandom_range(0, 2) != 0) tb_x = rnd_xfer();
            a_req = ta.req; a_we = ta.we; a_last = ta.last; a_addr = ta.addr; a_wdata = ta.data;
            b_req = tb_x.req; b_we = tb_x.we; b_last = tb_x.last; b_addr = tb_x.addr; b_wdata = tb_x.data;
            #2;
            if (owner == 1) who = ta.req ? 1 : 0;
            else if (owner == 2) who = tb_x.req ? 2 : 0;
            else if (ta.req && tb_x.req) who = (RR && turn == 1) ? 2 : 1;
            else who = ta.req ? 1 : (tb_x.req ? 2 : 0);
            g = (who == 1) ? ta : (who == 2) ? tb_x : '{default: '0};
            chk($sformatf("rnd%0d a_gnt", c), 32'(a_gnt), 32'(who == 1));
            chk($sformatf("rnd%0d b_gnt", c), 32'(b_gnt), 32'(who == 2));
            chk($sformatf("rnd%0d ram_we", c), 32'(ram_we), 32'(g.we));
            chk($sformatf("rnd%0d ram_addr", c), 32'(ram_addr), 32'(g.addr));
            chk($sformatf("rnd%0d ram_wdata", c), 32'(ram_wdata), 32'(g.data));
            chk($sformatf("rnd%0d a_rvalid", c), 32'(a_rvalid), 32'(exp_arv));
            chk($sformatf("rnd%0d b_rvalid", c), 32'(b_rvalid), 32'(exp_brv));
            if (exp_arv || exp_brv) chk($sformatf("rnd%0d rdata", c), 32'(exp_arv ? a_rdata : b_rdata), 32'(exp_rd));
            exp_arv = (who == 1) && !g.we;
            exp_brv = (who == 2) && !g.we;
            if (who != 0) begin
                if (g.we) ref_mem[g.addr] = g.data;
                else exp_rd = ref_mem[g.addr];
                owner = g.last ? 0 : who;
                if (g.last) turn = (who == 1) ? 1 : 0;
                if (who == 1) ta.req = 1'b0;
                else tb_x.req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
